// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard and scoreboard unit that sits beside decode. It keeps its own shadow
// copy of the destination registers in flight, so the later pipeline stages
// do not have to feed their instructions back. From that shadow pipeline it
// produces:
//   - one-hot forwarding selects for rs1/rs2 (youngest producer wins),
//   - load-use stalls for loads whose data is not yet forwardable,
//   - branch-flush squashing of decode and stage 1,
//   - a scoreboard for a single outstanding multi-cycle (mul/div) op.
//
// Handshake: decode presents an instruction with issue_valid. The instruction
// leaves decode (issue_fire=1) in a cycle where issue_valid=1, stall=0 and
// flush=0. Otherwise decode holds it, and a bubble enters stage 1. The back
// end never stalls, so the shadow pipeline shifts every cycle.
//
// Ports
//   clk, resetn        core clock, synchronous active-low reset
//   issue_valid        decode holds a valid instruction
//   issue_ra1/ra2      rs1/rs2 addresses, qualified by issue_ra1_ren/ra2_ren
//   issue_wa/wen       rd address and write enable
//   issue_is_load      instruction is a load
//   issue_is_long      instruction is a multi-cycle op
//   flush              taken branch/jump: squash decode and stage 1
//   stall              hold decode (combinational)
//   issue_fire         instruction leaves decode this cycle
//   a_fwd/b_fwd        one-hot forward selects, bit k-1 = stage k
//   long_busy/long_wa  long op outstanding and its reserved rd
//   long_done          long op writes back this cycle (one-cycle pulse)
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int NUM_STG  = 4,
  parameter int LOAD_LAT = 3,
  parameter int LONG_LAT = 8,
  parameter int AW       = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_ra1,
  input  logic [AW-1:0]      issue_ra2,
  input  logic               issue_ra1_ren,
  input  logic               issue_ra2_ren,
  input  logic [AW-1:0]      issue_wa,
  input  logic               issue_wen,
  input  logic               issue_is_load,
  input  logic               issue_is_long,
  input  logic               flush,
  output logic               stall,
  output logic               issue_fire,
  output logic [NUM_STG-1:0] a_fwd,
  output logic [NUM_STG-1:0] b_fwd,
  output logic               long_busy,
  output logic [AW-1:0]      long_wa,
  output logic               long_done
);

  localparam int CW = $clog2(LONG_LAT);

  // ---------------------------------------------------------------------------
  // Shadow pipeline. Index k holds stage k+1 (index 0 = one cycle after issue).
  // ---------------------------------------------------------------------------
  logic [NUM_STG-1:0] stg_vld;
  logic [NUM_STG-1:0] stg_wen;
  logic [NUM_STG-1:0] stg_load;
  logic [AW-1:0]      stg_wa [NUM_STG];

  // Long-op scoreboard state
  logic [CW-1:0]      long_cnt;
  logic               long_in_s1;   // long op issued last cycle, now in stage 1

  // Internal combinational results, gated by reset at the outputs
  logic               fire_int;
  logic               stall_int;
  logic               lu_stall;
  logic               long_stall;
  logic               long_done_int;

  logic [NUM_STG-1:0] a_match;
  logic [NUM_STG-1:0] b_match;
  logic [NUM_STG-1:0] a_sel;
  logic [NUM_STG-1:0] b_sel;
  logic [NUM_STG-1:0] early_mask;   // stages whose load data is not ready yet

  logic               ra1_live;
  logic               ra2_live;

  // x0 is hardwired zero: it never matches a producer.
  assign ra1_live = issue_ra1_ren & (issue_ra1 != '0);
  assign ra2_live = issue_ra2_ren & (issue_ra2 != '0);

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    assign a_match[k]    = stg_vld[k] & stg_wen[k] & (stg_wa[k] == issue_ra1) & ra1_live;
    assign b_match[k]    = stg_vld[k] & stg_wen[k] & (stg_wa[k] == issue_ra2) & ra2_live;
    assign early_mask[k] = ((k + 1) < LOAD_LAT);
  end

  // Isolate the lowest set bit: the youngest producer shadows older ones.
  assign a_sel = a_match & (~a_match + NUM_STG'(1));
  assign b_sel = b_match & (~b_match + NUM_STG'(1));

  // Load-use: the youngest producer is a load whose data is not yet available.
  // An older ALU producer hidden behind it does not help, so only the
  // selected stage is examined.
  assign lu_stall = (|(a_sel & stg_load & early_mask)) |
                    (|(b_sel & stg_load & early_mask));

  // While a long op is outstanding: a second long op has no unit to go to,
  // a reader of its rd must wait for the result (RAW), and a writer of its
  // rd would be overtaken by the late writeback (WAW).
  assign long_stall = long_busy & (
                        issue_is_long |
                        (ra1_live & (issue_ra1 == long_wa)) |
                        (ra2_live & (issue_ra2 == long_wa)) |
                        (issue_wen & (issue_wa != '0) & (issue_wa == long_wa)));

  assign stall_int = issue_valid & (lu_stall | long_stall);
  assign fire_int  = resetn & issue_valid & ~stall_int & ~flush;

  // A long op squashed out of stage 1 never writes back.
  assign long_done_int = long_busy & (long_cnt == CW'(1)) & ~(flush & long_in_s1);

  assign stall      = resetn & stall_int;
  assign issue_fire = fire_int;
  assign a_fwd      = (resetn & issue_valid) ? a_sel : '0;
  assign b_fwd      = (resetn & issue_valid) ? b_sel : '0;
  assign long_done  = resetn & long_done_int;

  // ---------------------------------------------------------------------------
  // Shadow pipeline shift. Long ops enter with wen cleared: their result is
  // tracked by the scoreboard, not by stage forwarding.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stg_vld  <= '0;
      stg_wen  <= '0;
      stg_load <= '0;
      for (int k = 0; k < NUM_STG; k++) begin
        stg_wa[k] <= '0;
      end
    end else begin
      stg_vld[0]  <= fire_int;
      stg_wen[0]  <= issue_wen & ~issue_is_long;
      stg_load[0] <= issue_is_load;
      stg_wa[0]   <= issue_wa;
      for (int k = 1; k < NUM_STG; k++) begin
        // flush kills the instruction currently in stage 1 as it moves on
        stg_vld[k]  <= stg_vld[k-1] & ~((k == 1) & flush);
        stg_wen[k]  <= stg_wen[k-1];
        stg_load[k] <= stg_load[k-1];
        stg_wa[k]   <= stg_wa[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Long-op scoreboard. cnt counts down to the writeback cycle (cnt==1).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      long_busy  <= 1'b0;
      long_cnt   <= '0;
      long_wa    <= '0;
      long_in_s1 <= 1'b0;
    end else begin
      long_in_s1 <= fire_int & issue_is_long;
      if (fire_int & issue_is_long) begin
        long_busy <= 1'b1;
        long_cnt  <= CW'(LONG_LAT - 1);
        long_wa   <= issue_wa;
      end else if (flush & long_in_s1) begin
        long_busy <= 1'b0;
        long_cnt  <= '0;
      end else if (long_busy) begin
        if (long_cnt == CW'(1)) begin
          long_busy <= 1'b0;
        end
        long_cnt <= long_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Directed testbench for pipe_hazard_unit with default parameters
// (NUM_STG=4, LOAD_LAT=3, LONG_LAT=8, AW=5). Inputs change on the falling
// edge; combinational outputs are checked 1 time unit later, well before the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  logic       clk;
  logic       resetn;
  logic       issue_valid;
  logic [4:0] issue_ra1;
  logic [4:0] issue_ra2;
  logic       issue_ra1_ren;
  logic       issue_ra2_ren;
  logic [4:0] issue_wa;
  logic       issue_wen;
  logic       issue_is_load;
  logic       issue_is_long;
  logic       flush;
  logic       stall;
  logic       issue_fire;
  logic [3:0] a_fwd;
  logic [3:0] b_fwd;
  logic       long_busy;
  logic [4:0] long_wa;
  logic       long_done;

  int n_chk;
  int n_err;

  pipe_hazard_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .issue_valid   (issue_valid),
    .issue_ra1     (issue_ra1),
    .issue_ra2     (issue_ra2),
    .issue_ra1_ren (issue_ra1_ren),
    .issue_ra2_ren (issue_ra2_ren),
    .issue_wa      (issue_wa),
    .issue_wen     (issue_wen),
    .issue_is_load (issue_is_load),
    .issue_is_long (issue_is_long),
    .flush         (flush),
    .stall         (stall),
    .issue_fire    (issue_fire),
    .a_fwd         (a_fwd),
    .b_fwd         (b_fwd),
    .long_busy     (long_busy),
    .long_wa       (long_wa),
    .long_done     (long_done)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [4:0] r1, input logic e1,
                       input logic [4:0] r2, input logic e2, input logic [4:0] w,
                       input logic we, input logic ld, input logic lg);
    issue_valid   = v;
    issue_ra1     = r1;
    issue_ra1_ren = e1;
    issue_ra2     = r2;
    issue_ra2_ren = e2;
    issue_wa      = w;
    issue_wen     = we;
    issue_is_load = ld;
    issue_is_long = lg;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
  endtask

  // advance to the next falling edge, then settle
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 10; i++) step();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    resetn = 1'b0;
    flush  = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    step();
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b exp 0", stall); end
    n_chk++; if (issue_fire !== 1'b0) begin n_err++; $display("FAIL rst_fire: got %b exp 0", issue_fire); end
    n_chk++; if (a_fwd !== 4'b0000) begin n_err++; $display("FAIL rst_afwd: got %b exp 0000", a_fwd); end
    n_chk++; if (b_fwd !== 4'b0000) begin n_err++; $display("FAIL rst_bfwd: got %b exp 0000", b_fwd); end
    n_chk++; if (long_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b exp 0", long_done); end
    n_chk++; if (long_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", long_busy); end
    n_chk++; if (long_wa !== 5'd0) begin n_err++; $display("FAIL rst_wa: got %0d exp 0", long_wa); end
    step();
    resetn = 1'b1;
    drain();
  endtask

  // addi x5 ; add x6,x5,x5 ; reader x5/x6 ; invalid reader
  task automatic test_forward();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL fwd_fire0: got %b exp 1", issue_fire); end
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (a_fwd !== 4'b0001) begin n_err++; $display("FAIL fwd_a1: got %b exp 0001", a_fwd); end
    n_chk++; if (b_fwd !== 4'b0001) begin n_err++; $display("FAIL fwd_b1: got %b exp 0001", b_fwd); end
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_stall1: got %b exp 0", stall); end
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (a_fwd !== 4'b0010) begin n_err++; $display("FAIL fwd_a2: got %b exp 0010", a_fwd); end
    n_chk++; if (b_fwd !== 4'b0001) begin n_err++; $display("FAIL fwd_b2: got %b exp 0001", b_fwd); end
    step();
    drive(1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (a_fwd !== 4'b0000) begin n_err++; $display("FAIL fwd_a_inv: got %b exp 0000", a_fwd); end
    n_chk++; if (issue_fire !== 1'b0) begin n_err++; $display("FAIL fwd_fire_inv: got %b exp 0", issue_fire); end
    drain();
  endtask

  // x3 in stage 1 and 3 -> youngest wins; x0 and ren=0 never forward
  task automatic test_priority();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (a_fwd !== 4'b0001) begin n_err++; $display("FAIL pri_a: got %b exp 0001", a_fwd); end
    n_chk++; if (b_fwd !== 4'b0000) begin n_err++; $display("FAIL pri_b_x0: got %b exp 0000", b_fwd); end
    step();
    // previous instruction wrote x0 and fired; x0 reader still gets nothing
    drive(1'b1, 5'd0, 1'b1, 5'd3, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (a_fwd !== 4'b0000) begin n_err++; $display("FAIL pri_a_x0: got %b exp 0000", a_fwd); end
    n_chk++; if (b_fwd !== 4'b0000) begin n_err++; $display("FAIL pri_b_noren: got %b exp 0000", b_fwd); end
    drain();
  endtask

  // lw x7 ; add x8,x7,x1 -> two stall cycles then forward from stage 3
  task automatic test_load_use();
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    #1;
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL lu_fire0: got %b exp 1", issue_fire); end
    step();
    drive(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_c%0d: got %b exp 1", c, stall); end
      n_chk++; if (issue_fire !== 1'b0) begin n_err++; $display("FAIL lu_fire_c%0d: got %b exp 0", c, issue_fire); end
      step();
    end
    #1;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_c3: got %b exp 0", stall); end
    n_chk++; if (a_fwd !== 4'b0100) begin n_err++; $display("FAIL lu_afwd_c3: got %b exp 0100", a_fwd); end
    n_chk++; if (b_fwd !== 4'b0000) begin n_err++; $display("FAIL lu_bfwd_c3: got %b exp 0000", b_fwd); end
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL lu_fire_c3: got %b exp 1", issue_fire); end
    drain();
  endtask

  // addi x3 ; lw x3 ; reader x3 -> younger load shadows older ALU producer
  task automatic test_shadow();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL sh_stall_c1: got %b exp 1", stall); end
    step();
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL sh_stall_c2: got %b exp 1", stall); end
    n_chk++; if (b_fwd !== 4'b0010) begin n_err++; $display("FAIL sh_bfwd_c2: got %b exp 0010", b_fwd); end
    step();
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL sh_stall_c3: got %b exp 0", stall); end
    n_chk++; if (b_fwd !== 4'b0100) begin n_err++; $display("FAIL sh_bfwd_c3: got %b exp 0100", b_fwd); end
    drain();
  endtask

  // mul x9 ; unrelated add ; WAW ; second long op ; RAW until long_done
  task automatic test_long();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL lg_fire0: got %b exp 1", issue_fire); end
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (long_busy !== 1'b1) begin n_err++; $display("FAIL lg_busy1: got %b exp 1", long_busy); end
    n_chk++; if (long_wa !== 5'd9) begin n_err++; $display("FAIL lg_wa1: got %0d exp 9", long_wa); end
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL lg_indep_stall: got %b exp 0", stall); end
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL lg_indep_fire: got %b exp 1", issue_fire); end
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL lg_waw_stall: got %b exp 1", stall); end
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
    #1;
    n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL lg_second_stall: got %b exp 1", stall); end
    step();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    for (int c = 4; c <= 7; c++) begin
      #1;
      n_chk++; if (stall !== 1'b1) begin n_err++; $display("FAIL lg_raw_stall_c%0d: got %b exp 1", c, stall); end
      n_chk++; if (long_done !== (c == 7)) begin n_err++; $display("FAIL lg_done_c%0d: got %b exp %b", c, long_done, (c == 7)); end
      n_chk++; if (a_fwd !== 4'b0000) begin n_err++; $display("FAIL lg_afwd_c%0d: got %b exp 0000", c, a_fwd); end
      step();
    end
    #1;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL lg_stall_c8: got %b exp 0", stall); end
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL lg_fire_c8: got %b exp 1", issue_fire); end
    n_chk++; if (long_busy !== 1'b0) begin n_err++; $display("FAIL lg_busy_c8: got %b exp 0", long_busy); end
    n_chk++; if (long_done !== 1'b0) begin n_err++; $display("FAIL lg_done_c8: got %b exp 0", long_done); end
    drain();
  endtask

  // lw x4 ; taken beq flushes it out of stage 1 ; reader of x4 two cycles later
  task automatic test_flush_load();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    n_chk++; if (issue_fire !== 1'b0) begin n_err++; $display("FAIL fl_fire: got %b exp 0", issue_fire); end
    step();
    idle();
    step();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b exp 0", stall); end
    n_chk++; if (a_fwd !== 4'b0000) begin n_err++; $display("FAIL fl_afwd: got %b exp 0000", a_fwd); end
    drain();
  endtask

  // mul x9 flushed from stage 1 -> scoreboard cleared, no writeback pulse
  task automatic test_flush_long();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    n_chk++; if (long_busy !== 1'b1) begin n_err++; $display("FAIL fll_busy_pre: got %b exp 1", long_busy); end
    n_chk++; if (long_done !== 1'b0) begin n_err++; $display("FAIL fll_done: got %b exp 0", long_done); end
    step();
    flush = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (long_busy !== 1'b0) begin n_err++; $display("FAIL fll_busy_post: got %b exp 0", long_busy); end
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL fll_stall: got %b exp 0", stall); end
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL fll_fire: got %b exp 1", issue_fire); end
    drain();
  endtask

  // reset in the middle of a long op (cnt=5) drops it and the pipeline
  task automatic test_reset_mid_long();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (long_busy !== 1'b1) begin n_err++; $display("FAIL rml_busy_pre: got %b exp 1", long_busy); end
    resetn = 1'b0;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL rml_stall: got %b exp 0", stall); end
    n_chk++; if (a_fwd !== 4'b0000) begin n_err++; $display("FAIL rml_afwd: got %b exp 0000", a_fwd); end
    n_chk++; if (issue_fire !== 1'b0) begin n_err++; $display("FAIL rml_fire: got %b exp 0", issue_fire); end
    step();
    n_chk++; if (long_busy !== 1'b0) begin n_err++; $display("FAIL rml_busy: got %b exp 0", long_busy); end
    n_chk++; if (long_wa !== 5'd0) begin n_err++; $display("FAIL rml_wa: got %0d exp 0", long_wa); end
    n_chk++; if (long_done !== 1'b0) begin n_err++; $display("FAIL rml_done: got %b exp 0", long_done); end
    resetn = 1'b1;
    #1;
    n_chk++; if (a_fwd !== 4'b0000) begin n_err++; $display("FAIL rml_afwd_post: got %b exp 0000", a_fwd); end
    n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL rml_stall_post: got %b exp 0", stall); end
    n_chk++; if (issue_fire !== 1'b1) begin n_err++; $display("FAIL rml_fire_post: got %b exp 1", issue_fire); end
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_chk  = 0;
    n_err  = 0;
    resetn = 1'b0;
    idle();
    test_reset();
    test_forward();
    test_priority();
    test_load_use();
    test_shadow();
    test_long();
    test_flush_load();
    test_flush_long();
    test_reset_mid_long();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
